// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side load/store handshake between the EXE/MEM stage logic and the
// SRAM controller.
interface mem_sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: serves 32-bit loads/stores as two 16-bit SRAM
// halfword phases and holds ready low to freeze the pipeline meanwhile.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_sram_ctrl_if.slave    bus,
  output logic [17:0]       sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned   CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic        is_wr;
  logic [16:0] word_q;
  logic [15:0] wdata_hi;
  logic [31:0] rdata_q;

  logic        req;
  logic [16:0] word_next;

  assign req       = bus.rd_en | bus.wr_en;
  // Word index wraps modulo 2^17; byte-offset bits fall away in the shift.
  assign word_next = 17'((bus.address - BASE_ADDR) >> 2);

  assign bus.ready     = (state == DONE) || ((state == IDLE) && !req);
  assign bus.read_data = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      word_q      <= '0;
      wdata_hi    <= '0;
      rdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LO;
            cnt         <= CNT_LOAD;
            is_wr       <= bus.wr_en;
            word_q      <= word_next;
            wdata_hi    <= bus.write_data[31:16];
            sram_addr   <= {word_next, 1'b0};
            sram_dq_out <= bus.write_data[15:0];
            sram_dq_oe  <= bus.wr_en;
            sram_we_n   <= !bus.wr_en;
            sram_oe_n   <= bus.wr_en;
          end
        end
        LO: begin
          if (cnt == '0) begin
            state       <= HI;
            cnt         <= CNT_LOAD;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_hi;
            if (!is_wr) rdata_q[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HI: begin
          if (cnt == '0) begin
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!is_wr) rdata_q[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: a behavioural SRAM, directed accesses
// and a monitor that checks each completed access against queued results.
module tb_mem_sram_ctrl;
  localparam int unsigned W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sram_ctrl_if bus ();
  mem_sram_ctrl_if bus1 ();

  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic [17:0] sram1_addr;
  logic [15:0] sram1_dq_out, sram1_dq_in;
  logic        sram1_dq_oe, sram1_we_n, sram1_oe_n;

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sram_addr(sram1_addr), .sram_dq_out(sram1_dq_out), .sram_dq_in(sram1_dq_in),
    .sram_dq_oe(sram1_dq_oe), .sram_we_n(sram1_we_n), .sram_oe_n(sram1_oe_n)
  );

  assign sram1_dq_in = '0;

  // SRAM needs a full W-cycle write pulse at one address before it commits.
  logic [15:0]  mem [0:262143];
  logic [17:0]  wa;
  int unsigned  wcnt = 0;
  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      if (wcnt != 0 && sram_addr == wa) wcnt = wcnt + 1;
      else begin
        wa   = sram_addr;
        wcnt = 1;
      end
      if (wcnt == W) mem[wa] = sram_dq_out;
    end else begin
      wcnt = 0;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    int unsigned done_cyc;
  } exp_t;
  exp_t sb[$];

  logic prev_ready = 1'b1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.ready && !prev_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: ready rose at cycle %0d with no access queued", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("read_data", bus.read_data, e.rdata);
        end
      end
      prev_ready = bus.ready;
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic [17:0] exp_lo, input logic b2b,
                        input logic change_addr, input string name);
    int unsigned seen;
    logic        done;
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = addr;
    bus.write_data = wdata;
    seen = b2b ? cyc + 1 : cyc;
    sb.push_back('{exp_rdata, seen + 2 * W + 1});
    if (b2b) begin
      @(negedge clk);
      check({name, "_gap_ready"}, bus.ready, 0);
      check({name, "_gap_we_n"}, sram_we_n, 1);
      check({name, "_gap_oe_n"}, sram_oe_n, 1);
    end
    for (int unsigned i = 1; i <= 2 * W; i++) begin
      @(negedge clk);
      check({name, "_busy_ready"}, bus.ready, 0);
      check({name, "_we_n"}, sram_we_n, !wr);
      check({name, "_oe_n"}, sram_oe_n, wr);
      check({name, "_dq_oe"}, sram_dq_oe, wr);
      check({name, "_sram_addr"}, sram_addr, (i <= W) ? exp_lo : (exp_lo | 18'h1));
      if (change_addr && i == 1) bus.address = addr + 32'd4;
    end
    done = 1'b0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(negedge clk);
      done = bus.ready;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready never rose, got 0 expected 1", name);
    end
    check({name, "_done_we_n"}, sram_we_n, 1);
  endtask

  task automatic go_idle();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stimulus
    logic seen_ready;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;

    rst             = 1'b1;
    bus.rd_en       = 1'b1;
    bus.wr_en       = 1'b0;
    bus.address     = 32'd1028;
    bus.write_data  = '0;
    bus1.rd_en      = 1'b0;
    bus1.wr_en      = 1'b0;
    bus1.address    = '0;
    bus1.write_data = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 0);
    check("rst_read_data", bus.read_data, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);

    rst = 1'b0;
    access(0, 1, 32'd1028, 32'h0, 32'hABCD1234, 18'h2, 0, 0, "rst_exit_load");
    go_idle();

    access(1, 0, 32'd1024, 32'hDEADBEEF, 32'hABCD1234, 18'h0, 0, 0, "store");
    go_idle();
    check("store_hw0", mem[0], 16'hBEEF);
    check("store_hw1", mem[1], 16'hDEAD);

    access(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'h0, 0, 0, "load_1024");
    go_idle();
    access(0, 1, 32'd1028, 32'h0, 32'hABCD1234, 18'h2, 0, 0, "load");
    go_idle();

    access(1, 0, 32'd1032, 32'h55AA00FF, 32'hABCD1234, 18'h4, 0, 0, "b2b_store");
    access(0, 1, 32'd1032, 32'h0, 32'h55AA00FF, 18'h4, 1, 0, "b2b_load");
    go_idle();

    access(0, 1, 32'd1028, 32'h0, 32'hABCD1234, 18'h2, 0, 1, "addr_change");
    go_idle();

    access(1, 1, 32'd1036, 32'h0BADF00D, 32'hABCD1234, 18'h6, 0, 0, "conflict");
    go_idle();
    check("conflict_hw6", mem[6], 16'hF00D);
    check("conflict_hw7", mem[7], 16'h0BAD);

    access(1, 0, 32'd1020, 32'h13579BDF, 32'hABCD1234, 18'h3FFFE, 0, 0, "wrap_store");
    go_idle();
    check("wrap_hw_lo", mem[18'h3FFFE], 16'h9BDF);
    check("wrap_hw_hi", mem[18'h3FFFF], 16'h1357);
    access(0, 1, 32'd1020, 32'h0, 32'h13579BDF, 18'h3FFFE, 0, 0, "wrap_load");
    go_idle();

    // Reset lands in the first HI cycle of a store; no completion is queued.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    check("midrst_hi_addr", sram_addr, 18'h9);
    check("midrst_hi_we_n", sram_we_n, 0);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("midrst_we_n", sram_we_n, 1);
    check("midrst_oe_n", sram_oe_n, 1);
    check("midrst_sram_addr", sram_addr, 0);
    check("midrst_ready", bus.ready, 1);
    check("midrst_read_data", bus.read_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hw8", mem[8], 16'hF00D);
    check("midrst_hw9", mem[9], 16'h0000);

    bus1.wr_en      = 1'b1;
    bus1.address    = 32'd1024;
    bus1.write_data = 32'h00000001;
    @(negedge clk);
    check("w1_c1_ready", bus1.ready, 0);
    check("w1_c1_we_n", sram1_we_n, 0);
    @(negedge clk);
    check("w1_c2_ready", bus1.ready, 0);
    check("w1_c2_addr", sram1_addr, 18'h1);
    @(negedge clk);
    check("w1_c3_ready", bus1.ready, 1);
    check("w1_c3_we_n", sram1_we_n, 1);
    bus1.wr_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", bus.ready, 1);
      check("idle_we_n", sram_we_n, 1);
      check("idle_oe_n", sram_oe_n, 1);
      check("idle_dq_oe", sram_dq_oe, 0);
    end

    seen_ready = 1'b0;
    for (int i = 0; i < 10 && !seen_ready; i++) begin
      if (sb.size() == 0) seen_ready = 1'b1;
      else @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d accesses never completed, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
